// File: rtl/mul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mul_seq_ctrl: multi-cycle unsigned multiply sequencer for the execute stage.
//
// Computes a WIDTH x WIDTH -> 2*WIDTH product by shift-and-add. A single
// WIDTH-bit adder is reused once per cycle for WIDTH cycles. This avoids a
// combinational array multiplier.
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   start    request, sampled in IDLE or DONE only
//   abort    synchronous cancel of an operation in RUN
//   a, b     multiplicand / multiplier, captured on an accepted start
//   busy     high while an operation is iterating
//   done     one-cycle pulse, product valid
//   product  result register, held until the next completion
// -----------------------------------------------------------------------------

// Shared WIDTH-bit adder with carry-out (a + b).
module half_adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b};
endmodule

module mul_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [CNT_W-1:0]   count;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               cout;
    logic [2*WIDTH-1:0] shifted;

    // The low accumulator bit selects whether this iteration adds the
    // multiplicand. acc_lo starts as the multiplier and is consumed LSB-first.
    assign addend = acc_lo[0] ? mcand : '0;

    half_adder #(.W(WIDTH)) u_adder (
        .a    (acc_hi),
        .b    (addend),
        .sum  (sum),
        .cout (cout)
    );

    // Right shift of {cout, sum, acc_lo}. The dropped bit is the multiplier
    // bit just consumed. The carry enters the top bit, so nothing is lost.
    assign shifted = {cout, sum, acc_lo[WIDTH-1:1]};

    // NOTE: every register here, datapath included, is cleared by the
    // asynchronous reset. product must read 0 immediately on reset, and the
    // accumulators are cheap enough that a uniform reset keeps the state
    // fully defined.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            mcand   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            count   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only. Every
            // right-hand side then sees pre-edge values, whatever the
            // statement order.
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand  <= a;
                        acc_hi <= '0;
                        acc_lo <= b;
                        count  <= '0;
                        state  <= RUN;
                        busy   <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        // abort takes priority over completion. product is untouched.
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        {acc_hi, acc_lo} <= shifted;
                        count            <= count + CNT_W'(1);
                        if (count == CNT_W'(WIDTH - 1)) begin
                            product <= shifted;
                            state   <= DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mul_seq_ctrl: scoreboard bench for mul_seq_ctrl.
// The stimulus pushes the expected product and the expected done cycle.
// The monitor pops the entry and compares it whenever done is seen.
// -----------------------------------------------------------------------------
module tb_mul_seq_ctrl;

    localparam int WIDTH = 32;
    localparam int LAT   = 33;   // edges from drive-time cycle count to done

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               abort;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    typedef struct {
        logic [2*WIDTH-1:0] prod;
        int unsigned        cyc;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    mul_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy_done_exclusive", {63'd0, busy & done}, 64'd0);
            if (done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", {63'd0, done}, 64'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("product", product, e.prod);
                    check("done_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    // Drive a start on a falling edge. The call returns one falling edge
    // later with start dropped, i.e. in the first busy cycle.
    task automatic do_start(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                            input bit expect_done, input logic [63:0] exp_prod);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        if (expect_done) begin
            e.prod = exp_prod;
            e.cyc  = cyc + LAT;
            sb_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            check("drain_timeout", 64'(sb_q.size()), 64'd0);
            sb_q.delete();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        a     = '0;
        b     = '0;

        // Reset state, before any clock edge.
        #1;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_product", product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 3 * 5: busy for exactly 32 cycles, then a single done.
        do_start(32'd3, 32'd5, 1'b1, 64'h0000_0000_0000_000F);
        for (int i = 0; i < 32; i++) begin
            check("busy_in_run", {63'd0, busy}, 64'd1);
            @(negedge clk);
        end
        check("done_after_32", {63'd0, done}, 64'd1);
        check("busy_low_in_done", {63'd0, busy}, 64'd0);
        @(negedge clk);
        check("done_one_cycle", {63'd0, done}, 64'd0);
        repeat (3) @(negedge clk);
        check("product_held", product, 64'h0000_0000_0000_000F);

        // Carry path, then a zero operand with the same latency.
        do_start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001);
        wait_drain();
        do_start(32'h0, 32'hDEAD_BEEF, 1'b1, 64'h0);
        wait_drain();

        // start during RUN is ignored.
        do_start(32'd7, 32'd6, 1'b1, 64'd42);
        repeat (9) @(negedge clk);
        start = 1'b1;
        a     = 32'd2;
        b     = 32'd2;
        @(negedge clk);
        start = 1'b0;
        wait_drain();
        repeat (40) @(negedge clk);
        check("ignored_start_product", product, 64'd42);

        // Back-to-back: a new start in the done cycle.
        do_start(32'h1234_5678, 32'h10, 1'b1, 64'h0000_0001_2345_6780);
        for (int i = 0; i < 100 && !done; i++) @(negedge clk);
        check("b2b_done_seen", {63'd0, done}, 64'd1);
        begin
            exp_t e;
            start  = 1'b1;
            a      = 32'd9;
            b      = 32'd9;
            e.prod = 64'd81;
            e.cyc  = cyc + LAT;
            sb_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", {63'd0, busy}, 64'd1);
        check("b2b_product_held", product, 64'h0000_0001_2345_6780);
        wait_drain();
        check("b2b_second_product", product, 64'd81);

        // Abort mid-RUN.
        do_start(32'd100, 32'd100, 1'b0, 64'd0);
        repeat (14) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_mid_busy", {63'd0, busy}, 64'd0);
        check("abort_mid_product", product, 64'd81);
        repeat (40) @(negedge clk);

        // Abort on the final iteration edge.
        do_start(32'd100, 32'd100, 1'b0, 64'd0);
        repeat (31) @(negedge clk);
        check("abort_last_busy_before", {63'd0, busy}, 64'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_last_done", {63'd0, done}, 64'd0);
        check("abort_last_busy", {63'd0, busy}, 64'd0);
        check("abort_last_product", product, 64'd81);
        repeat (40) @(negedge clk);

        // Reset asserted asynchronously mid-RUN.
        do_start(32'd5, 32'd7, 1'b0, 64'd0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", {63'd0, busy}, 64'd0);
        check("async_rst_done", {63'd0, done}, 64'd0);
        check("async_rst_product", product, 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("post_rst_product", product, 64'd0);
        do_start(32'd2, 32'd3, 1'b1, 64'd6);
        wait_drain();
        check("post_rst_result", product, 64'd6);

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Multi-cycle unsigned multiply sequencer for the KGP-RISC execute stage.
- Computes a WIDTH x WIDTH -> 2*WIDTH product by iterative shift-and-add.
- Time-multiplexes a single instance of the existing 32-bit adder module half_adder (a+b with carry-out) over WIDTH cycles, instead of building a combinational array multiplier.
- Sits beside the ALU. The core stalls on busy and captures product when done pulses.

Parameters:
- WIDTH, 32: operand width; must equal the adder width (32).
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- abort  input  1  synchronous cancel of an in-flight operation.
- a  input  WIDTH  multiplicand; captured on an accepted start.
- b  input  WIDTH  multiplier; captured on an accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; product is valid.
- product  output  2*WIDTH  result register; holds its value until the next completion.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, takes effect immediately, no clock needed):
  - state=IDLE, busy=0, done=0, product=0.
  - Internal mcand, acc_hi, acc_lo, carry and count all 0.
- States: IDLE, RUN, DONE. Encoding is free; no illegal state may be reachable.
- IDLE:
  - start=1 at edge k: mcand<=a, acc_hi<=0, acc_lo<=b, count<=0, state<=RUN.
  - busy reads 1 in the cycle after edge k.
  - start=0: remain in IDLE.
- RUN, one iteration per cycle:
  - Adder inputs: a=acc_hi, b=(acc_lo[0] ? mcand : 0).
  - Then {acc_hi, acc_lo} <= {cout, sum, acc_lo[WIDTH-1:1]}, i.e. a 2*WIDTH+1-bit right shift that brings cout into the MSB.
  - count<=count+1.
  - No overflow is possible: the result always fits in 2*WIDTH bits.
- RUN exit: on the edge where count==WIDTH-1 (the WIDTH-th iteration):
  - product<=the shifted {acc_hi, acc_lo}, state<=DONE.
  - busy deasserts and done asserts in the following cycle.
- Latency: fixed at WIDTH+1 cycles from the accepting edge to done=1, regardless of operand values. Zero operands are not short-circuited.
- DONE: done=1 for exactly one cycle.
  - start=1: accepted exactly as in IDLE (back-to-back operation, no bubble).
  - start=0: state<=IDLE.
- start while in RUN: ignored; operands are not recaptured and there is no queuing.
- abort while in RUN: state<=IDLE at the next edge.
  - product is unchanged and done is not asserted.
  - abort has priority over the final-iteration transition.
  - abort in IDLE or DONE: no effect (start still accepted in DONE).
- Reset asserted mid-RUN: immediate return to IDLE with product=0. No done pulse after reset deasserts.
- Outputs:
  - busy and done are registered, decoded from the state register.
  - done and busy are never high together.
  - product changes only on a completing edge or on reset.

Test Plan:
- Reset, then start with a=3, b=5 at edge k -> busy=1 for cycles k+1..k+32; done=1 only in cycle k+33; product=0x0000_0000_0000_000F, held afterwards.
- a=0xFFFF_FFFF, b=0xFFFF_FFFF -> product=0xFFFF_FFFE_0000_0001 (exercises the carry path). Then a=0, b=0xDEAD_BEEF -> product=0 with the same 33-cycle latency.
- Start a=7, b=6; in the 10th busy cycle pulse start with a=2, b=2 -> the second request is ignored; product=42 (0x2A) at the expected cycle; no second done.
- Start a=0x1234_5678, b=0x10 -> done; assert start with a=9, b=9 in the done cycle -> busy the next cycle; product=0x1_2345_6780 until the second done, then 81.
- Start a=100, b=100; pulse abort mid-RUN -> IDLE, no done, product keeps its prior value. Repeat with abort on the final iteration cycle -> still no done.
- Drop rst_n asynchronously (between edges) mid-RUN -> busy, done and product go to 0 immediately; after release, no spurious done; a fresh start of a=2, b=3 gives 6.
